fetch_stage: RTL

Instruction-fetch front end of the Zeptron pipeline. It is the producer side of the instruction word that `decode_stage` consumes. It owns the fetch PC and issues word requests to instruction memory over a request/grant, in-order-response interface. Returned words are buffered with their PCs and handed to decode over a valid/ready handshake. Branch and jump redirects flush the buffer and discard responses that are still in flight.

---
 rtl/zeptron_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/zeptron_pkg.sv
`default_nettype none
// ============================================================================
// Module      : zeptron_pkg
// Description : Shared types and constants for the Zeptron fetch front end.
//               fetch_entry_t   - buffered instruction word with its PC
//               NOP_INSTR       - addi x0,x0,0 encoding
//               RESET_PC_DEFAULT- default fetch address after reset
// Revision    : 1.0 - initial release
// ============================================================================
package zeptron_pkg;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // Word-align a fetch address.
    function automatic logic [31:0] align_pc(input logic [31:0] i_a);
        return {i_a[31:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch_entry_t with flush. Push and pop in
//               the same cycle on a full FIFO is legal. Flush wins over both.
// Ports       : clk, rst (async, active-high)
//               i_flush      - empty the FIFO
//               i_push       - write i_push_data at the tail
//               i_pop        - drop the head entry
//               o_head       - head entry (stable while not popped)
//               o_count      - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import zeptron_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  fetch_entry_t               i_push_data,
    input  logic                       i_pop,
    output fetch_entry_t               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_wr;
    logic [PW-1:0]   r_rd;
    logic [CW-1:0]   r_count;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] i_p);
        return (i_p == PW'(DEPTH - 1)) ? '0 : i_p + 1'b1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_push_data;
                r_wr        <= ptr_next(r_wr);
            end
            if (i_pop) begin
                r_rd <= ptr_next(r_rd);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Zeptron instruction-fetch front end. Owns the fetch PC, issues
//               word requests to instruction memory (request/grant, in-order
//               responses), buffers returned words with their PCs and hands
//               them to decode over valid/ready. Redirects flush the buffer
//               and discard responses still in flight.
// Ports       : clk, reset (async, active-high)
//               imem_req/imem_addr/imem_gnt        - request channel
//               imem_rvalid/imem_rdata             - response channel
//               redirect/redirect_pc               - flush and restart
//               d_valid/d_ready/d_instr/d_pc       - decode handshake
//               d_misaligned                       - only with FETCH_MISALIGN_EN
// Options     : FETCH_MISALIGN_EN - a redirect to a non-word-aligned target
//               stops fetch and presents a single nop flagged misaligned.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage
    import zeptron_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_instr,
`ifdef FETCH_MISALIGN_EN
    output logic [31:0] d_pc,
    output logic        d_misaligned
`else
    output logic [31:0] d_pc
`endif
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_resp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_drop;

    logic [CW-1:0] w_count;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_pop;
    logic          w_push;
    logic          w_issue;
    logic          w_resp_keep;
    logic [SW-1:0] w_used;
    logic          w_halt;
    logic          w_nop_push;

    assign d_valid = (w_count != '0);
    assign w_pop   = d_valid && d_ready;

    // Credits: buffer slots not yet claimed by a buffered or in-flight word,
    // counting the slot freed by this cycle's pop.
    assign w_used   = SW'(r_out) + SW'(w_count) - SW'(w_pop);
    assign imem_req = !redirect && !w_halt && (w_used < SW'(DEPTH));
    assign imem_addr = r_pc;
    assign w_issue   = imem_req && imem_gnt;

    assign w_resp_keep = imem_rvalid && (r_drop == '0) && !redirect;
    assign w_push      = w_resp_keep || w_nop_push;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_drop    <= '0;
        end else begin
            // No issue can happen during a redirect, so one update covers both.
            r_out <= r_out + CW'(w_issue) - CW'(imem_rvalid);
            if (redirect) begin
                r_pc      <= align_pc(redirect_pc);
                r_resp_pc <= align_pc(redirect_pc);
                r_drop    <= r_out - CW'(imem_rvalid);
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_resp_keep) begin
                    r_resp_pc <= r_resp_pc + 32'd4;
                end
                if (imem_rvalid && (r_drop != '0)) begin
                    r_drop <= r_drop - 1'b1;
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_EN
    logic        r_halt;
    logic        r_nop_pend;
    logic        r_mis_flag;
    logic [31:0] r_mis_pc;

    // Once everything in flight has drained (and been discarded) the fake
    // nop is the only entry that can ever sit in the buffer while halted.
    assign w_nop_push = r_nop_pend && (r_out == '0) && !redirect;
    assign w_halt     = r_halt;
    assign w_push_data = w_nop_push ? '{instr: NOP_INSTR, pc: r_mis_pc}
                                    : '{instr: imem_rdata, pc: r_resp_pc};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_halt     <= 1'b0;
            r_nop_pend <= 1'b0;
            r_mis_flag <= 1'b0;
            r_mis_pc   <= '0;
        end else if (redirect) begin
            r_halt     <= |redirect_pc[1:0];
            r_nop_pend <= |redirect_pc[1:0];
            r_mis_flag <= 1'b0;
            r_mis_pc   <= redirect_pc;
        end else if (w_nop_push) begin
            r_nop_pend <= 1'b0;
            r_mis_flag <= 1'b1;
        end else if (w_pop) begin
            r_mis_flag <= 1'b0;
        end
    end

    assign d_misaligned = r_mis_flag;
`else
    logic w_unused;

    assign w_nop_push  = 1'b0;
    assign w_halt      = 1'b0;
    assign w_push_data = '{instr: imem_rdata, pc: r_resp_pc};
    assign w_unused    = &{1'b0, redirect_pc[1:0]};
`endif

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign d_instr = w_head.instr;
    assign d_pc    = w_head.pc;

endmodule
`default_nettype wire
